// File: rtl/data_sram_responder.sv
// Responder for the CPU data-SRAM port: word RAM plus memory-mapped LED/switch/number/timer registers.
// Optional free-running timer at offset 0xE000 is built only when DATA_SRAM_RESPONDER_TIMER_EN is defined.
module data_sram_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
  parameter logic [31:0] CONF_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF010;
  localparam logic [15:0] OFF_NUM    = 16'hF020;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;

  logic [31:0] mem [2**RAM_AW];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [31:0] timer_val;

  logic              conf_hit;
  logic [15:0]       conf_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_any;
  logic [31:0]       conf_rdata;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign conf_hit = ((data_sram_addr & CONF_MASK) == CONF_BASE);
  assign conf_off = {data_sram_addr[15:2], 2'b00};
  assign ram_idx  = data_sram_addr[RAM_AW+1:2];
  assign wr_any   = |data_sram_we;

`ifdef DATA_SRAM_RESPONDER_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // A store to the timer overrides that cycle's increment.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (data_sram_en && conf_hit && conf_off == OFF_TIMER && wr_any)
      timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_we);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer_q <= 32'd0;
    else         timer_q <= timer_d;
  end

  assign timer_val = timer_q;
`else
  assign timer_val = 32'd0;
`endif

  always_comb begin
    conf_rdata = 32'd0;
    unique case (conf_off)
      OFF_LED:    conf_rdata = {16'd0, led_q};
      OFF_SWITCH: conf_rdata = {24'd0, sw_sync_q};
      OFF_NUM:    conf_rdata = num_q;
`ifdef DATA_SRAM_RESPONDER_TIMER_EN
      OFF_TIMER:  conf_rdata = timer_val;
`endif
      default:    conf_rdata = 32'd0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    led_d   = led_q;
    num_d   = num_q;
    if (data_sram_en) begin
      rdata_d = conf_hit ? conf_rdata : mem[ram_idx];
      if (conf_hit && conf_off == OFF_LED) begin
        if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
        if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
      end
      if (conf_hit && conf_off == OFF_NUM)
        num_d = merge_bytes(num_q, data_sram_wdata, data_sram_we);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= 32'd0;
      led_q     <= 16'd0;
      num_q     <= 32'd0;
      sw_meta_q <= 8'd0;
      sw_sync_q <= 8'd0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      num_q     <= num_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM has no reset; writes are suppressed while reset is held so in-flight stores are dropped.
  always_ff @(posedge clk) begin
    if (resetn && data_sram_en && !conf_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder end of the CPU data-SRAM interface: accepts the core's `data_sram_en/we/addr/wdata` requests and returns `data_sram_rdata` with fixed one-cycle latency. Decodes each request into a word-addressed RAM or a small memory-mapped configuration register region (LED, switch, number display, free-running timer). It sits beside the CPU top in the SoC wrapper and replaces the bare data RAM so programs can drive board I/O through ordinary loads and stores.

## Interface
Parameters:
- `RAM_AW`, 14: RAM word-address width; depth is 2^RAM_AW 32-bit words.
- `CONF_BASE`, 32'hBFAF_0000: base address of the config region.
- `CONF_MASK`, 32'hFFFF_0000: a request hits the config region when `(addr & CONF_MASK) == CONF_BASE`.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `resetn` input 1: reset, **asynchronous assert, active-low**.
- `data_sram_en` input 1: request valid this cycle.
- `data_sram_we` input 4: byte-lane write enables; 0 = read.
- `data_sram_addr` input 32: byte address; bits [1:0] are ignored.
- `data_sram_wdata` input 32: write data, lane i = bits [8i+7:8i].
- `data_sram_rdata` output 32: read data, valid the cycle after the request.
- `switch` input 8: asynchronous board switches.
- `led` output 16: LED register.
- `num_data` output 32: number-display register.

## Operation
- Decode: a config hit is selected by `CONF_MASK`/`CONF_BASE`. Any other address is RAM, indexed by `addr[RAM_AW+1:2]`. Upper address bits alias.
- RAM write: at a posedge with `en` = 1, each lane with `we[i]` = 1 is written. Lanes with `we[i]` = 0 are untouched. RAM contents are not reset.
- RAM read: at a posedge with `en` = 1, `rdata` registers the word's pre-write content. This applies even when `we` != 0 (read-before-write).
- Config offsets use `addr[15:0]`:
  - 0xF000 LED: RW, lanes 0–1 only.
  - 0xF010 SWITCH: RO, returns `{24'b0, switch_sync}`.
  - 0xF020 NUM: RW, all lanes.
  - 0xE000 TIMER: RW, all lanes.
- Any other offset reads 0 and ignores writes. Config reads also register into `rdata` one cycle later, returning the pre-write value.
- `switch` passes through a 2-flop synchronizer. `switch_sync` therefore lags the pin by 2 cycles.
- TIMER is a 32-bit counter that increments by 1 every cycle and wraps 0xFFFF_FFFF→0.
  - A TIMER write wins over the increment in that cycle: timer = byte-merged wdata, and increments resume the next cycle.
  - A TIMER read returns the value held during the request cycle.
- When `en` = 0, `rdata` holds its previous value and no state other than TIMER and the synchronizer changes.
- `led` and `num_data` drive their registers directly.

## Timing
- Read latency is exactly 1 cycle. Requests are accepted back-to-back every cycle with no stall and no ready signal.
- Write side-effects become visible on outputs (`led`, `num_data`) the cycle after the write edge. A read of the same address in the next cycle returns the new data.
- Reset values, applied asynchronously on `resetn` low: `rdata` = 0, `led` = 16'h0000, `num_data` = 0, timer = 0, synchronizer flops = 0.
- Reset release is synchronous to `clk`. The first request is honoured at the first posedge with `resetn` high.
- Reset asserted mid-operation: the in-flight read result is discarded (`rdata` = 0) and pending writes at that edge are dropped. RAM keeps its contents.

## Configuration
- Macro `DATA_SRAM_RESPONDER_TIMER_EN`:
  - Defined: the TIMER register and its counter are built as described above.
  - Undefined: no counter is instantiated. Offset 0xE000 behaves as unmapped (reads 0, writes ignored).

## Test plan
- **RAM byte write and readback:** write 0x11223344 (we=F) to 0x0000_0010, then write 0xAA with we=4'b0010 to the same address, then read. Required `rdata` one cycle after the read request is 0x1122AA44.
- **Back-to-back and read-before-write:**
  - Reads of 0x0, 0x4, 0x8 on consecutive cycles return their words on the next three cycles.
  - A write request with we=F returns the old word on `rdata`.
- **LED/NUM:**
  - Write 0xFFFF_1234 to 0xBFAF_F000: `led` = 0x1234 next cycle.
  - Write 0xDEADBEEF to 0xBFAF_F020: `num_data` = 0xDEADBEEF.
  - Reading 0xBFAF_F000 returns 0x0000_1234.
- **Switch:** set `switch` = 0x5A, wait 2 cycles, read 0xBFAF_F010. Required `rdata` = 0x0000_005A.
- **Timer (macro defined):**
  - Write 0xFFFF_FFFE to 0xBFAF_E000, then read on the immediately next cycle: returns 0xFFFF_FFFE.
  - A read 2 cycles after the write returns 0xFFFF_FFFF; one cycle later it returns 0x0000_0000 (wrap).
  - With the macro undefined, the same read returns 0.
- **Reset mid-stream:** drop `resetn` for 2 cycles while reads are in flight. Required: `rdata`, `led`, `num_data` all go to 0 immediately; RAM data written before the reset still reads back correctly afterwards.
